// File: rtl/vending_ctrl_param.sv
// Credit-counter vending controller: accepts coins up to a ceiling, requests a vend
// once credit reaches the price, then pays back any remainder one coin at a time.
module vending_ctrl_param #(
    parameter int PRICE      = 25,
    parameter int MAX_CREDIT = 95,
    parameter int CW         = 7
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_nickle,
    input  logic          i_dime,
    input  logic          i_quarter,
    input  logic          i_cancel,
    input  logic          i_vend_ack,
    input  logic          i_coin_ready,
    output logic          o_soda,
    output logic          o_coin_reject,
    output logic          o_chg_nickle,
    output logic          o_chg_dime,
    output logic          o_chg_quarter,
    output logic [CW-1:0] o_credit,
    output logic          o_busy
);

    localparam int W = CW + 1;
    localparam logic [CW:0] L_PRICE   = W'(PRICE);
    localparam logic [CW:0] L_MAX     = W'(MAX_CREDIT);
    localparam logic [CW:0] L_NICKLE  = W'(5);
    localparam logic [CW:0] L_DIME    = W'(10);
    localparam logic [CW:0] L_QUARTER = W'(25);

    typedef enum logic [1:0] {
        S_ACCEPT = 2'd0,
        S_VEND   = 2'd1,
        S_CHANGE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_credit;
    logic [CW-1:0] w_credit_nx;
    logic          r_soda, w_soda_nx;
    logic          r_reject, w_reject_nx;
    logic          r_chg_n, w_chg_n_nx;
    logic          r_chg_d, w_chg_d_nx;
    logic          r_chg_q, w_chg_q_nx;
    logic          r_busy;

    logic          w_coin_any;
    logic          w_coin_multi;
    logic [CW:0]   w_coin_val;
    logic [CW:0]   w_credit_ext;
    logic [CW:0]   w_sum;
    logic [CW:0]   w_after_vend;
    logic [CW:0]   w_chg_val;
    logic [CW:0]   w_after_chg;

    assign w_coin_any   = i_nickle | i_dime | i_quarter;
    assign w_coin_multi = (i_quarter & i_dime) | (i_quarter & i_nickle) | (i_dime & i_nickle);
    assign w_coin_val   = i_quarter ? L_QUARTER :
                          i_dime    ? L_DIME    :
                          i_nickle  ? L_NICKLE  : '0;

    // One extra bit on every sum/difference so the ceiling compare never sees a wrap
    assign w_credit_ext = {1'b0, r_credit};
    assign w_sum        = w_credit_ext + w_coin_val;
    assign w_after_vend = w_credit_ext - L_PRICE;
    assign w_chg_val    = (w_credit_ext >= L_QUARTER) ? L_QUARTER :
                          (w_credit_ext >= L_DIME)    ? L_DIME    : L_NICKLE;
    assign w_after_chg  = w_credit_ext - w_chg_val;

    always_comb begin
        w_state_nx  = r_state;
        w_credit_nx = r_credit;
        w_soda_nx   = 1'b0;
        w_reject_nx = 1'b0;
        w_chg_n_nx  = 1'b0;
        w_chg_d_nx  = 1'b0;
        w_chg_q_nx  = 1'b0;
        case (r_state)
            S_ACCEPT: begin
                if (i_cancel && (r_credit != '0)) begin
                    w_state_nx  = S_CHANGE;
                    w_reject_nx = w_coin_any;
                end else if (w_coin_any) begin
                    if (w_sum > L_MAX) begin
                        w_reject_nx = 1'b1;
                    end else begin
                        w_credit_nx = w_sum[CW-1:0];
                        w_reject_nx = w_coin_multi;
                        if (w_sum >= L_PRICE) begin
                            w_state_nx = S_VEND;
                            w_soda_nx  = 1'b1;
                        end
                    end
                end
            end
            S_VEND: begin
                w_reject_nx = w_coin_any;
                if (i_vend_ack) begin
                    w_credit_nx = w_after_vend[CW-1:0];
                    w_state_nx  = (w_after_vend != '0) ? S_CHANGE : S_ACCEPT;
                end else begin
                    w_soda_nx = 1'b1;
                end
            end
            S_CHANGE: begin
                w_reject_nx = w_coin_any;
                // Largest coin that still fits; credit is always a multiple of 5
                if (i_coin_ready) begin
                    w_credit_nx = w_after_chg[CW-1:0];
                    w_chg_q_nx  = (w_chg_val == L_QUARTER);
                    w_chg_d_nx  = (w_chg_val == L_DIME);
                    w_chg_n_nx  = (w_chg_val == L_NICKLE);
                    if (w_after_chg == '0) begin
                        w_state_nx = S_ACCEPT;
                    end
                end
            end
            default: begin
                w_state_nx = S_ACCEPT;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state  <= S_ACCEPT;
            r_credit <= '0;
            r_soda   <= 1'b0;
            r_reject <= 1'b0;
            r_chg_n  <= 1'b0;
            r_chg_d  <= 1'b0;
            r_chg_q  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_credit <= w_credit_nx;
            r_soda   <= w_soda_nx;
            r_reject <= w_reject_nx;
            r_chg_n  <= w_chg_n_nx;
            r_chg_d  <= w_chg_d_nx;
            r_chg_q  <= w_chg_q_nx;
            r_busy   <= (w_state_nx != S_ACCEPT);
        end
    end

    assign o_soda        = r_soda;
    assign o_coin_reject = r_reject;
    assign o_chg_nickle  = r_chg_n;
    assign o_chg_dime    = r_chg_d;
    assign o_chg_quarter = r_chg_q;
    assign o_credit      = r_credit;
    assign o_busy        = r_busy;

endmodule
